ps2_scan_decoder: RTL and testbench
===================================

# ps2_scan_decoder

Decodes the PS/2 Set-2 scan-code byte stream into key events. Sits directly downstream of the PS/2 byte receiver and consumes its `rx_data` / `rx_done_tick` pair. Folds E0 (extended) and F0 (break) prefixes into single make/break events, and discards the Pause (E1) sequence and keyboard status bytes. Queues events in a small FIFO behind a valid/ready handshake for the strum note logic.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset; sampled on `posedge clk`.
- `rx_data`  in  8  received byte; valid only in the cycle `rx_done_tick`=1.
- `rx_done_tick`  in  1  one-cycle byte strobe from the receiver.
- `ev_valid`  out  1  FIFO non-empty; head event presented.
- `ev_code`  out  8  head event scan code (prefixes stripped).
- `ev_ext`  out  1  head event was E0-prefixed.
- `ev_break`  out  1  1 = key release, 0 = key press.
- `ev_ready`  in  1  consumer accepts the head event when `ev_valid & ev_ready`.
- `ev_overflow`  out  1  one-cycle pulse when a decoded event is dropped because the FIFO is full.
- `busy`  out  1  decoder holds a partial prefix or Pause skip, i.e. state ≠ IDLE.

## Operation
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. It advances only on cycles where `rx_done_tick`=1.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → SKIP with skip counter = 7.
  - AA, FA, FE, EE, 00, FF: ignored; stay IDLE.
  - Any other byte: emit {code, ext=0, break=0}.
- EXT: F0 → EXT_BRK. E0 → stay EXT. Other byte: emit {code, ext=1, break=0}, go to IDLE.
- BRK: emit {code, ext=0, break=1}, go to IDLE. A second F0 is emitted as a code; no special case.
- EXT_BRK: emit {code, ext=1, break=1}, go to IDLE.
- SKIP: each byte decrements the 3-bit counter. The byte that brings it to 0 returns the FSM to IDLE. Nothing is emitted; the full 8-byte Pause sequence is swallowed.
- FIFO behaviour:
  - Push occurs on emit.
  - Pop occurs on `ev_valid & ev_ready`.
  - Outputs `ev_code` / `ev_ext` / `ev_break` are the head entry and are held stable while `ev_valid & ~ev_ready`.
  - Full with no pop: the new event is dropped, `ev_overflow` pulses, and the FSM still advances.
  - Full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Empty: head outputs hold their last value; `ev_valid`=0.
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo the depth. The count is one bit wider.
- Reset values: FSM = IDLE, skip counter = 0, FIFO empty. `ev_valid`, `ev_code`, `ev_ext`, `ev_break`, `ev_overflow` and `busy` are all 0.
- A reset during a prefix or skip discards the partial sequence and returns to IDLE.

## Timing
- Latency: an emit-causing byte with `rx_done_tick` at cycle N gives `ev_valid`=1 at cycle N+1, provided the FIFO was empty.
- The FSM is registered. Its next state is computed combinationally from the current state and `rx_data`.
- `ev_overflow` is registered and asserted at cycle N+1 for 1 cycle.
- `busy` is high from the cycle after a prefix or E1 byte until the cycle after the terminating byte.
- Back-to-back `rx_done_tick` on consecutive cycles must be handled, even though the receiver cannot produce them.

## Configuration
- `PS2_DEC_TYPEMATIC_FILTER_EN` defined:
  - Adds a 512-bit held-key map indexed by {ext, code}.
  - A make event sets its bit. A make event whose bit is already set is suppressed: not pushed, no overflow pulse.
  - A break event clears its bit and is always pushed.
  - Reset clears the map.
  - The map updates on decode regardless of whether the FIFO accepted the push.
- Not defined: no map is built; every typematic repeat make is pushed.

## Structure
- `ps2_pkg` holds:
  - Decoder state enum.
  - Prefix constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_PAUSE`=8'hE1.
  - Ignore-list byte constants.
  - `PS2_PAUSE_SKIP`=7.
  - Event struct {code[7:0], ext, brk}.
- Sub-module `ps2_evt_fifo`: a synchronous FIFO parameterised by depth. It takes push/pop/data-in, provides head/empty/full, and implements the full-with-pop accept rule.
- The decoder FSM and the optional held-key map live in the top module.

## Test plan
- Bytes 1C, then F0 1C → event {1C, ext 0, break 0} one cycle after the 1C tick, then event {1C, ext 0, break 1}; `busy`=1 between F0 and the second 1C.
- Bytes E0 75, then E0 F0 75 → events {75, ext 1, break 0} and {75, ext 1, break 1}.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 → only {29, ext 0, break 0} is emitted; `busy` returns to 0 after the 8th byte.
- `ev_ready`=0, FIFO_DEPTH=4, six make codes 15 1D 24 2D 2C 35 → first four queued in order; `ev_overflow` pulses twice. Raise `ev_ready` → 15, 1D, 24, 2D popped one per cycle.
- FIFO full with `ev_ready`=1 and a new code arriving in the same cycle → push accepted; no overflow; count stays 4.
- Filter macro on: 1C 1C 1C F0 1C 1C → events make 1C, break 1C, make 1C only. Filter macro off: five events. Reset asserted mid-prefix (after F0) → next byte 1C emits a make, not a break.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 Set-2 scan decoder shared types and constants.
// Optional feature macro: PS2_DEC_TYPEMATIC_FILTER_EN (used by ps2_scan_decoder).
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Keyboard status / protocol bytes that never map to a key
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;

    // Bytes following E1 in the Pause sequence
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK)    || (b == PS2_RESEND) ||
               (b == PS2_ECHO)   || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous key-event FIFO; a push while full is accepted only if a pop
// happens in the same cycle. Head is registered so it holds when empty.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  ps2_evt_t din,
    output ps2_evt_t head,
    output logic     empty,
    output logic     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    ps2_evt_t         mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic             push_acc;
    logic             pop_acc;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    // Next occupancy and read pointer
    always_comb begin
        count_next  = count;
        rd_ptr_next = rd_ptr;
        if (pop_acc) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        case ({push_acc, pop_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, count and registered head; head bypasses din when the
    // pushed entry becomes the new head in the same cycle it is written
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (count_next != '0) begin
                if (push_acc && (wr_ptr == rd_ptr_next)) begin
                    head <= din;
                end else begin
                    head <= mem[rd_ptr_next];
                end
            end
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan-code to key-event decoder with event FIFO.
// Optional: define PS2_DEC_TYPEMATIC_FILTER_EN to suppress typematic repeat makes.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    input  logic       ev_ready,
    output logic       ev_overflow,
    output logic       busy
);

    ps2_state_t state;
    ps2_state_t state_next;
    logic [2:0] skip_cnt;
    logic [2:0] skip_next;
    logic       emit;
    ps2_evt_t   evt;
    logic       suppress;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    ps2_evt_t   head;

    // Next-state and event decode; only advances on a byte strobe
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        emit       = 1'b0;
        evt        = '0;
        evt.code   = rx_data;
        if (rx_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == PS2_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_data == PS2_BRK) begin
                        state_next = ST_BRK;
                    end else if (rx_data == PS2_PAUSE) begin
                        state_next = ST_SKIP;
                        skip_next  = PS2_PAUSE_SKIP;
                    end else if (!is_status_byte(rx_data)) begin
                        emit = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_data == PS2_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (rx_data != PS2_EXT) begin
                        emit       = 1'b1;
                        evt.ext    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit       = 1'b1;
                    evt.brk    = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    emit       = 1'b1;
                    evt.ext    = 1'b1;
                    evt.brk    = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_next = skip_cnt - 1'b1;
                    if (skip_cnt == 3'd1) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Decoder state and Pause skip counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
    logic [511:0] held;
    logic [8:0]   key_idx;

    assign key_idx  = {evt.ext, evt.code};
    assign suppress = emit & ~evt.brk & held[key_idx];

    // Held-key map: set on make, clear on break, independent of FIFO accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            held <= '0;
        end else if (emit) begin
            held[key_idx] <= ~evt.brk;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign push = emit & ~suppress;
    assign pop  = ev_valid & ev_ready;

    // Overflow pulse when a decoded event finds no room
    always_ff @(posedge clk) begin
        if (!reset) begin
            ev_overflow <= 1'b0;
        end else begin
            ev_overflow <= push & fifo_full & ~pop;
        end
    end

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (evt),
        .head (head),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_break = head.brk;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: stimulus queues expected events,
// a negedge monitor checks every accepted head event against the queue.
module tb_ps2_scan_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done_tick = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_ready = 1'b0;
    logic       ev_overflow;
    logic       busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned ovf_cnt = 0;
    logic [9:0]  exp_q[$];

    always #5 clk = ~clk;

    ps2_scan_decoder #(
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done_tick(rx_done_tick),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .ev_ext      (ev_ext),
        .ev_break    (ev_break),
        .ev_ready    (ev_ready),
        .ev_overflow (ev_overflow),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void expect_ev(input logic [7:0] code, input logic ext, input logic brk);
        exp_q.push_back({code, ext, brk});
    endfunction

    // Monitor: handshake completes at the coming posedge
    always @(negedge clk) begin
        if (reset) begin
            if (ev_overflow) ovf_cnt++;
            if (ev_valid && ev_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got %0h/%0b/%0b expected none",
                             ev_code, ev_ext, ev_break);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({ev_code, ev_ext, ev_break} !== e) begin
                        miscompares++;
                        $display("FAIL event: got %0h/%0b/%0b expected %0h/%0b/%0b",
                                 ev_code, ev_ext, ev_break, e[9:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    // Byte strobe coincident with consumer accepting the head
    task automatic send_byte_pop(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data      = b;
        rx_done_tick = 1'b1;
        ev_ready     = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        ev_ready     = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] fill_codes [6];
        pause_seq  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        fill_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", ev_valid, 0);
        check("rst_head", {ev_code, ev_ext, ev_break}, 0);
        check("rst_ovf", ev_overflow, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        // Make then break, latency and busy
        ev_ready = 1'b0;
        expect_ev(8'h1C, 0, 0);
        send_byte(8'h1C);
        check("latency_valid", ev_valid, 1);
        ev_ready = 1'b1;
        expect_ev(8'h1C, 0, 1);
        send_byte(8'hF0);
        check("busy_brk", busy, 1);
        send_byte(8'h1C);
        check("busy_brk_done", busy, 0);
        drain("drain_basic");

        // Extended make / break, including repeated E0
        expect_ev(8'h75, 1, 0);
        expect_ev(8'h75, 1, 1);
        send_byte(8'hE0);
        check("busy_ext", busy, 1);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("busy_ext_brk", busy, 1);
        send_byte(8'h75);
        check("busy_ext_done", busy, 0);
        drain("drain_ext");

        // Status bytes ignored
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'h00);
        check("status_idle", {ev_valid, busy}, 0);

        // Pause sequence swallowed
        for (int unsigned i = 0; i < 8; i++) begin
            send_byte(pause_seq[i]);
            check("pause_busy", busy, (i < 7) ? 1 : 0);
        end
        check("pause_no_event", ev_valid, 0);
        expect_ev(8'h29, 0, 0);
        send_byte(8'h29);
        drain("drain_pause");

        // Overflow with stalled consumer
        ev_ready = 1'b0;
        ovf_cnt  = 0;
        for (int unsigned i = 0; i < 4; i++) expect_ev(fill_codes[i], 0, 0);
        for (int unsigned i = 0; i < 6; i++) send_byte(fill_codes[i]);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_pulses", ovf_cnt, 2);
        check("stall_head", {ev_valid, ev_code}, {1'b1, 8'h15});
        ev_ready = 1'b1;
        drain("drain_ovf");
        check("empty_hold_code", {ev_valid, ev_code}, {1'b0, 8'h2D});

        // Full with simultaneous pop and push
        ev_ready = 1'b0;
        ovf_cnt  = 0;
        expect_ev(8'h16, 0, 0);
        expect_ev(8'h1E, 0, 0);
        expect_ev(8'h26, 0, 0);
        expect_ev(8'h25, 0, 0);
        expect_ev(8'h2E, 0, 0);
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        send_byte_pop(8'h2E);
        repeat (2) @(posedge clk);
        #1;
        check("full_pop_no_ovf", ovf_cnt, 0);
        check("full_pop_head", {ev_valid, ev_code}, {1'b1, 8'h1E});
        ev_ready = 1'b1;
        drain("drain_full_pop");

        // Typematic repeats
        expect_ev(8'h1C, 0, 0);
`ifndef PS2_DEC_TYPEMATIC_FILTER_EN
        expect_ev(8'h1C, 0, 0);
        expect_ev(8'h1C, 0, 0);
`endif
        expect_ev(8'h1C, 0, 1);
        expect_ev(8'h1C, 0, 0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        drain("drain_typematic");

        // Reset mid-prefix discards the break prefix
        send_byte(8'hF0);
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_busy", busy, 0);
        check("reset_valid", ev_valid, 0);
        reset = 1'b1;
        expect_ev(8'h1C, 0, 0);
        send_byte(8'h1C);
        drain("drain_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
